vga_pp: RTL

VGA_PP -- requirements
Module: vga_pp

---
 rtl/vga_pp.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/vga_pp.sv
// vga_pp: VGA raster timing with a DMA-fed word FIFO and pixel shifter.
// Define VGA_UNDERRUN_FLAG_EN to add the sticky underrun status port.
module vga_pp #(
  parameter int BPP        = 1,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vack,
  input  logic [15:0] pixels_in,
  output logic        vreq,
  output logic        vreset,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic [1:0]  r,
  output logic [1:0]  g,
  output logic [1:0]  b
`ifdef VGA_UNDERRUN_FLAG_EN
  ,
  output logic        underrun
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PB      = $clog2(16 / BPP);
  localparam int WORDS   = H_ACTIVE * V_ACTIVE * BPP / 16;
  localparam int FW      = $clog2(WORDS + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;

  if ((H_ACTIVE * BPP) % 16 != 0) begin : g_bad_width
    $error("vga_pp: H_ACTIVE*BPP must be a multiple of 16");
  end
  if (BPP != 1 && BPP != 2 && BPP != 4) begin : g_bad_bpp
    $error("vga_pp: BPP must be 1, 2 or 4");
  end
  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("vga_pp: FIFO_DEPTH must be a power of 2, >= 2");
  end

  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic          run;
  logic          active;
  logic          first;
  logic          hs_on;
  logic          vs_on;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          full;
  logic          empty;
  logic          wr;
  logic          pop;
  logic [FW-1:0] fcnt;
  logic [15:0]   word;
  logic [15:0]   sr;
  logic [BPP-1:0] pix;
  logic [1:0]    cr;
  logic [1:0]    cg;
  logic [1:0]    cb;

  assign active = (int'(hc) < H_ACTIVE) && (int'(vc) < V_ACTIVE);
  assign first  = active && (hc[PB-1:0] == '0);
  assign hs_on  = (int'(hc) >= H_ACTIVE + H_FP) &&
                  (int'(hc) <  H_ACTIVE + H_FP + H_SYNC);
  assign vs_on  = (int'(vc) >= V_ACTIVE + V_FP) &&
                  (int'(vc) <  V_ACTIVE + V_FP + V_SYNC);
  assign vreset = (hc == '0) && (int'(vc) == V_ACTIVE + V_FP);

  assign full  = (int'(cnt) == FIFO_DEPTH);
  assign empty = (cnt == '0);
  assign wr    = vack && !full && !vreset;
  assign pop   = first && !empty;
  assign vreq  = run && !full && (int'(fcnt) < WORDS) && !vreset;

  // an empty FIFO at a word boundary yields a black word
  assign word = empty ? 16'h0000 : mem[rp];
  assign pix  = first ? word[15 -: BPP] : sr[15 -: BPP];

  if (BPP == 1) begin : g_c1
    assign cr = {pix[0], pix[0]};
    assign cg = {pix[0], pix[0]};
    assign cb = {pix[0], pix[0]};
  end else if (BPP == 2) begin : g_c2
    assign cr = pix[1:0];
    assign cg = pix[1:0];
    assign cb = pix[1:0];
  end else begin : g_c4
    assign cr = {pix[2], pix[3]};
    assign cg = {pix[1], pix[3]};
    assign cb = {pix[0], pix[3]};
  end

  // raster counters; vc steps on hc wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else if (int'(hc) == H_TOTAL - 1) begin
      hc <= '0;
      vc <= (int'(vc) == V_TOTAL - 1) ? '0 : vc + VW'(1);
    end else begin
      hc <= hc + HW'(1);
    end
  end

  // holds vreq low for the cycle in which reset releases
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // FIFO storage; contents are qualified by the pointers
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= pixels_in;
  end

  // FIFO pointers and occupancy; vreset flushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (vreset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr)  wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + CW'(wr) - CW'(pop);
    end
  end

  // words fetched this frame, saturating at one frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        fcnt <= '0;
    else if (vreset)                   fcnt <= '0;
    else if (wr && int'(fcnt) < WORDS) fcnt <= fcnt + FW'(1);
  end

  // pixel shifter: load on word boundary, shift MSB-first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sr <= '0;
    else if (first)  sr <= word << BPP;
    else if (active) sr <= sr << BPP;
  end

  // registered sync and colour outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
      r       <= '0;
      g       <= '0;
      b       <= '0;
    end else begin
      hsync_n <= !hs_on;
      vsync_n <= !vs_on;
      r       <= active ? cr : 2'b00;
      g       <= active ? cg : 2'b00;
      b       <= active ? cb : 2'b00;
    end
  end

`ifdef VGA_UNDERRUN_FLAG_EN
  // sticky underrun, cleared at the frame's DMA restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              underrun <= 1'b0;
    else if (vreset)         underrun <= 1'b0;
    else if (first && empty) underrun <= 1'b1;
  end
`endif

endmodule
